// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and source IDs for the RegFile write arbiter
package regfile_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int NUM_REGS   = 1 << ADDR_W;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - shift-register writeback FIFO; entry 0 is the head, tags expose entry address fields
module wb_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2,
    parameter int TAG_W = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0][TAG_W-1:0]  tags
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push;
    logic                        do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[0];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_pop  = pop && !empty;
        do_push = push && !full;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            count_d = count_q - CW'(1);
        end
        // Push lands after the post-pop tail, so a simultaneous pop/push keeps order.
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_d) begin
                    mem_d[i] = push_data;
                end
            end
            count_d = count_d + CW'(1);
        end
    end

    always_comb begin
        tags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tags[i] = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - arrival-ordered arbiter of ALU and MEM writebacks onto the RegFile write port
module regfile_wr_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = regfile_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     Write_enable,
    output logic [ADDR_W-1:0]        Write_Add,
    output logic [DATA_W-1:0]        Write_data,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic                     idle
);

    import regfile_pkg::src_e;
    import regfile_pkg::SRC_ALU;
    import regfile_pkg::SRC_MEM;

    localparam int EW = ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int QD = 2 * DEPTH;
    localparam int QW = $clog2(QD + 1);

    logic                         alu_push, mem_push;
    logic                         alu_pop, mem_pop;
    logic [EW-1:0]                alu_head, mem_head;
    logic                         alu_full, mem_full;
    logic                         alu_empty, mem_empty;
    logic [CW-1:0]                alu_count, mem_count;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_tags, mem_tags;

    src_e                         oq_q [QD];
    src_e                         oq_d [QD];
    logic [QW-1:0]                oq_cnt_q, oq_cnt_d;
    logic                         oq_pop;

    logic                         we_q, we_d;
    logic [ADDR_W-1:0]            add_q, add_d;
    logic [DATA_W-1:0]            data_q, data_d;

    assign alu_ready = !rst && !alu_full;
    assign mem_ready = !rst && !mem_full;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .TAG_W(ADDR_W), .CW(CW)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .push_data ({alu_addr, alu_data}),
        .pop       (alu_pop),
        .head      (alu_head),
        .full      (alu_full),
        .empty     (alu_empty),
        .count     (alu_count),
        .tags      (alu_tags)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .TAG_W(ADDR_W), .CW(CW)) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_push),
        .push_data ({mem_addr, mem_data}),
        .pop       (mem_pop),
        .head      (mem_head),
        .full      (mem_full),
        .empty     (mem_empty),
        .count     (mem_count),
        .tags      (mem_tags)
    );

    assign oq_pop = (oq_cnt_q != '0);

    // MEM is appended ahead of ALU on a shared edge: the MEM-stage instruction is older.
    always_comb begin
        oq_d     = oq_q;
        oq_cnt_d = oq_cnt_q;
        if (oq_pop) begin
            for (int i = 0; i < QD - 1; i++) begin
                oq_d[i] = oq_q[i + 1];
            end
            oq_cnt_d = oq_cnt_q - QW'(1);
        end
        if (mem_push) begin
            for (int i = 0; i < QD; i++) begin
                if (QW'(i) == oq_cnt_d) begin
                    oq_d[i] = SRC_MEM;
                end
            end
            oq_cnt_d = oq_cnt_d + QW'(1);
        end
        if (alu_push) begin
            for (int i = 0; i < QD; i++) begin
                if (QW'(i) == oq_cnt_d) begin
                    oq_d[i] = SRC_ALU;
                end
            end
            oq_cnt_d = oq_cnt_d + QW'(1);
        end
    end

    always_comb begin
        we_d    = 1'b0;
        add_d   = add_q;
        data_d  = data_q;
        alu_pop = 1'b0;
        mem_pop = 1'b0;
        if (oq_pop) begin
            we_d = 1'b1;
            if (oq_q[0] == SRC_MEM) begin
                mem_pop         = 1'b1;
                {add_d, data_d} = mem_head;
            end else begin
                alu_pop         = 1'b1;
                {add_d, data_d} = alu_head;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < alu_count) begin
                pending[alu_tags[i]] = 1'b1;
            end
            if (CW'(i) < mem_count) begin
                pending[mem_tags[i]] = 1'b1;
            end
        end
        if (we_q) begin
            pending[add_q] = 1'b1;
        end
    end

    assign idle         = alu_empty && mem_empty && !we_q;
    assign Write_enable = we_q;
    assign Write_Add    = add_q;
    assign Write_data   = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QD; i++) begin
                oq_q[i] <= SRC_ALU;
            end
            oq_cnt_q <= '0;
            we_q     <= 1'b0;
            add_q    <= '0;
            data_q   <= '0;
        end else begin
            oq_q     <= oq_d;
            oq_cnt_q <= oq_cnt_d;
            we_q     <= we_d;
            add_q    <= add_d;
            data_q   <= data_d;
        end
    end

endmodule
